// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory, decode and execute.
interface instr_fetch_unit_if;
    localparam int unsigned DataW = 32;

    logic             IMemReq;
    logic [DataW-1:0] IMemAddr;
    logic             IMemValid;
    logic [DataW-1:0] IMemRData;
    logic [DataW-1:0] Instr;
    logic [DataW-1:0] InstrPC;
    logic [DataW-1:0] PCPlus8;
    logic             InstrValid;
    logic             InstrReady;
    logic             BranchTaken;
    logic [DataW-1:0] BranchPCPlus8;
    logic [DataW-1:0] ExtImm;
    logic             FetchFault;

    // Fetch unit side
    modport master (
        output IMemReq, IMemAddr, Instr, InstrPC, PCPlus8, InstrValid, FetchFault,
        input  IMemValid, IMemRData, InstrReady, BranchTaken, BranchPCPlus8, ExtImm
    );

    // Memory / decode / execute side
    modport slave (
        input  IMemReq, IMemAddr, Instr, InstrPC, PCPlus8, InstrValid, FetchFault,
        output IMemValid, IMemRData, InstrReady, BranchTaken, BranchPCPlus8, ExtImm
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one-outstanding word reads and hands the
// fetched instruction to decode over a valid/ready handshake. Taken branches
// redirect the PC; a response already in flight for the old PC is dropped.
// Optional memory-timeout fault enabled by defining IFU_TIMEOUT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic                clk,
    input logic                reset,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned AddrW = 32;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} fetchStateT;

    // Elaboration-time parameter sanity checks
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : gBadTimeout
        $error("TIMEOUT_CYCLES must be within 2..255");
    end
    if (RESET_PC[1:0] != 2'b00) begin : gBadResetPc
        $error("RESET_PC must be word aligned");
    end

    fetchStateT       state;
    logic [AddrW-1:0] pc;
    logic             drop;
    logic             reqQ;
    logic [AddrW-1:0] instrQ;
    logic [AddrW-1:0] instrPCQ;
    logic [AddrW-1:0] pcPlus8Q;
    logic             validQ;
    logic [AddrW-1:0] branchTarget;

    // Redirect target, forced to a word boundary
    assign branchTarget = (bus.BranchPCPlus8 + bus.ExtImm) & 32'hFFFF_FFFC;

`ifdef IFU_TIMEOUT_EN
    localparam int unsigned CntW = 8;
    localparam logic [CntW-1:0] TimeoutLimit = CntW'(TIMEOUT_CYCLES);
    logic [CntW-1:0] waitCnt;
    logic            faultQ;
`endif

    // Fetch FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            reqQ     <= 1'b0;
            instrQ   <= '0;
            instrPCQ <= '0;
            pcPlus8Q <= '0;
            validQ   <= 1'b0;
`ifdef IFU_TIMEOUT_EN
            waitCnt  <= '0;
            faultQ   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.BranchTaken) pc <= branchTarget;
                    reqQ  <= 1'b1;
                    state <= REQ;
                end
                REQ: begin
                    reqQ  <= 1'b0;
                    state <= WAIT;
`ifdef IFU_TIMEOUT_EN
                    waitCnt <= '0;
`endif
                    if (bus.BranchTaken) begin
                        pc   <= branchTarget;
                        drop <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.IMemValid) begin
                        if (drop || bus.BranchTaken) begin
                            // Stale response: discard and fetch the redirected PC
                            if (bus.BranchTaken) pc <= branchTarget;
                            drop  <= 1'b0;
                            reqQ  <= 1'b1;
                            state <= REQ;
                        end else begin
                            instrQ   <= bus.IMemRData;
                            instrPCQ <= pc;
                            pcPlus8Q <= pc + 32'd8;
                            validQ   <= 1'b1;
                            state    <= HOLD;
                        end
                    end else begin
                        if (bus.BranchTaken) begin
                            pc   <= branchTarget;
                            drop <= 1'b1;
                        end
`ifdef IFU_TIMEOUT_EN
                        waitCnt <= waitCnt + 8'd1;
                        if (waitCnt + 8'd1 == TimeoutLimit) begin
                            faultQ <= 1'b1;
                            reqQ   <= 1'b0;
                            validQ <= 1'b0;
                            state  <= FAULT;
                        end
`endif
                    end
                end
                HOLD: begin
                    if (bus.BranchTaken) begin
                        pc     <= branchTarget;
                        validQ <= 1'b0;
                        reqQ   <= 1'b1;
                        state  <= REQ;
                    end else if (bus.InstrReady) begin
                        pc     <= pc + 32'd4;
                        validQ <= 1'b0;
                        reqQ   <= 1'b1;
                        state  <= REQ;
                    end
                end
                FAULT: begin
                    reqQ   <= 1'b0;
                    validQ <= 1'b0;
                end
                default: begin
                    reqQ   <= 1'b0;
                    validQ <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.IMemReq    = reqQ;
    assign bus.IMemAddr   = pc;
    assign bus.Instr      = instrQ;
    assign bus.InstrPC    = instrPCQ;
    assign bus.PCPlus8    = pcPlus8Q;
    assign bus.InstrValid = validQ;
`ifdef IFU_TIMEOUT_EN
    assign bus.FetchFault = faultQ;
`else
    assign bus.FetchFault = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table for the
// basic fetch/backpressure/HOLD-branch flow, then hand-written sequences for
// redirects during an outstanding read, PC wrap and the memory timeout.
module tb_instr_fetch_unit;
    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    instr_fetch_unit_if ifc();

    instr_fetch_unit #(
        .RESET_PC      (32'h0000_0000),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: responds memLat cycles after seeing a request
    int          memLat    = 1;
    bit          memSilent = 1'b0;
    int          memCnt    = 0;
    logic [31:0] memAddr   = '0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'hE3A0_1005 ^ a;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            memCnt        = 0;
            ifc.IMemValid = 1'b0;
            ifc.IMemRData = '0;
        end else begin
            ifc.IMemValid = 1'b0;
            if (memCnt > 0) begin
                memCnt--;
                if (memCnt == 0 && !memSilent) begin
                    ifc.IMemValid = 1'b1;
                    ifc.IMemRData = memWord(memAddr);
                end
            end
            if (ifc.IMemReq) begin
                memAddr = ifc.IMemAddr;
                memCnt  = memLat;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic driveIn(input logic rdy, input logic br, input logic [31:0] bpc8, input logic [31:0] ext);
        ifc.InstrReady    = rdy;
        ifc.BranchTaken   = br;
        ifc.BranchPCPlus8 = bpc8;
        ifc.ExtImm        = ext;
    endtask

    // Hold reset, check reset values, release on a falling edge
    task automatic doReset();
        reset = 1'b1;
        driveIn(1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        chk("rst_req",   ifc.IMemReq,    0);
        chk("rst_valid", ifc.InstrValid, 0);
        chk("rst_instr", ifc.Instr,      0);
        chk("rst_pc",    ifc.InstrPC,    0);
        chk("rst_pc8",   ifc.PCPlus8,    0);
        chk("rst_fault", ifc.FetchFault, 0);
        chk("rst_addr",  ifc.IMemAddr,   0);
        reset = 1'b0;
    endtask

    typedef struct {
        logic        rdy;
        logic        br;
        logic [31:0] bpc8;
        logic [31:0] ext;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] eInstr;
        logic [31:0] ePC;
    } vecT;

    function automatic vecT mk(input logic rdy, input logic br, input logic [31:0] bpc8,
                               input logic [31:0] ext, input logic eReq, input logic [31:0] eAddr,
                               input logic eValid, input logic [31:0] eInstr, input logic [31:0] ePC);
        vecT v;
        v.rdy = rdy; v.br = br; v.bpc8 = bpc8; v.ext = ext;
        v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid; v.eInstr = eInstr; v.ePC = ePC;
        return v;
    endfunction

    localparam int NumVec = 25;
    vecT vec[NumVec];

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        driveIn(1'b0, 1'b0, '0, '0);

        // Expected outputs observed at each falling edge, then inputs for the next rising edge
        vec[0]  = mk(0, 0, 0, 0,                   0, 32'h0,  0, 0, 0);
        vec[1]  = mk(0, 0, 0, 0,                   1, 32'h0,  0, 0, 0);
        vec[2]  = mk(0, 0, 0, 0,                   0, 32'h0,  0, 0, 0);
        vec[3]  = mk(0, 0, 0, 0,                   0, 32'h0,  1, 32'hE3A0_1005, 32'h0);
        vec[4]  = mk(0, 0, 0, 0,                   0, 32'h0,  1, 32'hE3A0_1005, 32'h0);
        vec[5]  = mk(0, 0, 0, 0,                   0, 32'h0,  1, 32'hE3A0_1005, 32'h0);
        vec[6]  = mk(0, 0, 0, 0,                   0, 32'h0,  1, 32'hE3A0_1005, 32'h0);
        vec[7]  = mk(0, 0, 0, 0,                   0, 32'h0,  1, 32'hE3A0_1005, 32'h0);
        vec[8]  = mk(1, 0, 0, 0,                   0, 32'h0,  1, 32'hE3A0_1005, 32'h0);
        vec[9]  = mk(0, 0, 0, 0,                   1, 32'h4,  0, 0, 0);
        vec[10] = mk(0, 0, 0, 0,                   0, 32'h0,  0, 0, 0);
        vec[11] = mk(1, 0, 0, 0,                   0, 32'h0,  1, 32'hE3A0_1001, 32'h4);
        vec[12] = mk(0, 0, 0, 0,                   1, 32'h8,  0, 0, 0);
        vec[13] = mk(0, 0, 0, 0,                   0, 32'h0,  0, 0, 0);
        vec[14] = mk(1, 0, 0, 0,                   0, 32'h0,  1, 32'hE3A0_100D, 32'h8);
        vec[15] = mk(0, 0, 0, 0,                   1, 32'hC,  0, 0, 0);
        vec[16] = mk(0, 0, 0, 0,                   0, 32'h0,  0, 0, 0);
        vec[17] = mk(1, 0, 0, 0,                   0, 32'h0,  1, 32'hE3A0_1009, 32'hC);
        vec[18] = mk(0, 0, 0, 0,                   1, 32'h10, 0, 0, 0);
        vec[19] = mk(0, 0, 0, 0,                   0, 32'h0,  0, 0, 0);
        vec[20] = mk(0, 1, 32'h18, 32'hFFFF_FFF0,  0, 32'h0,  1, 32'hE3A0_1015, 32'h10);
        vec[21] = mk(0, 0, 0, 0,                   1, 32'h8,  0, 0, 0);
        vec[22] = mk(0, 0, 0, 0,                   0, 32'h0,  0, 0, 0);
        vec[23] = mk(1, 1, 32'h10, 32'h30,         0, 32'h0,  1, 32'hE3A0_100D, 32'h8);
        vec[24] = mk(0, 0, 0, 0,                   1, 32'h40, 0, 0, 0);

        // Fetch, backpressure and branch-in-HOLD flow
        memLat = 1; memSilent = 1'b0;
        doReset();
        for (int i = 0; i < NumVec; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("v%0d_req", i),   ifc.IMemReq,    vec[i].eReq);
            chk($sformatf("v%0d_valid", i), ifc.InstrValid, vec[i].eValid);
            if (vec[i].eReq)
                chk($sformatf("v%0d_addr", i), ifc.IMemAddr, vec[i].eAddr);
            if (vec[i].eValid) begin
                chk($sformatf("v%0d_instr", i), ifc.Instr,   vec[i].eInstr);
                chk($sformatf("v%0d_ipc", i),   ifc.InstrPC, vec[i].ePC);
                chk($sformatf("v%0d_pc8", i),   ifc.PCPlus8, vec[i].ePC + 32'd8);
            end
            driveIn(vec[i].rdy, vec[i].br, vec[i].bpc8, vec[i].ext);
        end

        // Branch in the first WAIT cycle with a 3-cycle memory
        memLat = 3;
        doReset();
        @(negedge clk);
        chk("bw_req", ifc.IMemReq, 1);
        @(negedge clk);
        driveIn(1'b0, 1'b1, 32'h0000_00F8, 32'h8);
        @(negedge clk);
        driveIn(1'b0, 1'b0, '0, '0);
        n = 0;
        while (!ifc.IMemReq && n < 20) begin
            chk("bw_novalid", ifc.InstrValid, 0);
            @(negedge clk);
            n++;
        end
        chk("bw_lat",  n, 2);
        chk("bw_addr", ifc.IMemAddr, 32'h100);
        n = 0;
        while (!ifc.InstrValid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bw_got",   ifc.InstrValid, 1);
        chk("bw_ipc",   ifc.InstrPC, 32'h100);
        chk("bw_instr", ifc.Instr,   32'hE3A0_1105);

        // Branch in REQ, then a second branch while the stale response arrives
        memLat = 1;
        doReset();
        @(negedge clk);
        chk("br_req", ifc.IMemReq, 1);
        driveIn(1'b0, 1'b1, 32'h0000_01F8, 32'h8);
        @(negedge clk);
        chk("br_wait", ifc.IMemReq, 0);
        driveIn(1'b0, 1'b1, 32'h0000_0278, 32'h8);
        @(negedge clk);
        driveIn(1'b0, 1'b0, '0, '0);
        chk("br_req2",  ifc.IMemReq,    1);
        chk("br_addr2", ifc.IMemAddr,   32'h280);
        chk("br_novld", ifc.InstrValid, 0);

        // Wrap-around: branch to the last word, unaligned target sum
        doReset();
        repeat (3) @(negedge clk);
        chk("wr_hold", ifc.InstrValid, 1);
        driveIn(1'b0, 1'b1, 32'hFFFF_FFF4, 32'hB);
        @(negedge clk);
        driveIn(1'b0, 1'b0, '0, '0);
        chk("wr_req",  ifc.IMemReq,  1);
        chk("wr_addr", ifc.IMemAddr, 32'hFFFF_FFFC);
        repeat (2) @(negedge clk);
        chk("wr_valid", ifc.InstrValid, 1);
        chk("wr_instr", ifc.Instr,      32'h1C5F_EFF9);
        chk("wr_ipc",   ifc.InstrPC,    32'hFFFF_FFFC);
        chk("wr_pc8",   ifc.PCPlus8,    32'h0000_0004);
        driveIn(1'b1, 1'b0, '0, '0);
        @(negedge clk);
        driveIn(1'b0, 1'b0, '0, '0);
        chk("wr_req2",  ifc.IMemReq,  1);
        chk("wr_addr2", ifc.IMemAddr, 32'h0);

        // Silent memory
        memSilent = 1'b1;
        doReset();
        @(negedge clk);
        chk("to_req", ifc.IMemReq, 1);
`ifdef IFU_TIMEOUT_EN
        repeat (4) @(negedge clk);
        chk("to_nofault", ifc.FetchFault, 0);
        @(negedge clk);
        chk("to_fault", ifc.FetchFault, 1);
        driveIn(1'b0, 1'b1, 32'h0000_0100, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            driveIn(1'b0, 1'b0, '0, '0);
            chk("to_sticky", ifc.FetchFault, 1);
            chk("to_noreq",  ifc.IMemReq,    0);
            chk("to_noval",  ifc.InstrValid, 0);
        end
`else
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("to_nofault", ifc.FetchFault, 0);
            chk("to_noreq",   ifc.IMemReq,    0);
            chk("to_noval",   ifc.InstrValid, 0);
        end
`endif
        memSilent = 1'b0;
        doReset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
